// File: rtl/dac_update_sequencer.sv
// ---------------------------------------------------------------------------
// dac_update_sequencer
//
// Watches writes into a 16-entry DAC register file. Each written channel is
// marked dirty. Dirty channels are sent to an LTC2668-style DAC one at a time
// in round-robin order. Each frame is three bytes on an external SPI byte
// master: command nibble, channel nibble, then the 16-bit code.
//
// Parameters
//   CMD_CODE  command nibble placed in the top of every frame
//   CS_GAP    minimum idle cycles (chip select high) between frames, 1..15
//
// Ports
//   i_FPGA_clk      system clock, rising edge
//   i_FPGA_rst      asynchronous reset, active low
//   i_write         register-file write strobe (one cycle per write)
//   i_waddr         channel being written while i_write is high
//   o_raddr         register-file read address
//   i_rdData        register-file read data, valid one cycle after o_raddr
//   i_enable        high allows a new frame to start
//   i_master_ready  SPI master can accept a byte
//   o_TXByte        byte handed to the SPI master
//   o_TXdv          one-cycle byte-valid strobe
//   o_cs_n          DAC chip select, active low
//   o_busy          high whenever the sequencer is not idle
//   o_done          one-cycle pulse as a frame completes (o_cs_n rising)
//
// Timing note: every output is a register. An action named for a state
// (for example "assert chip select" in LATCH) becomes visible in the cycle
// after that state. So o_cs_n falls as SEND begins, o_TXdv is high during
// the first WAITLOW cycle, and o_done/o_cs_n rise together as GAP begins.
// ---------------------------------------------------------------------------
module dac_update_sequencer #(
  parameter logic [3:0]  CMD_CODE = 4'b0011,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic        i_FPGA_clk,
  input  logic        i_FPGA_rst,
  input  logic        i_write,
  input  logic [3:0]  i_waddr,
  output logic [3:0]  o_raddr,
  input  logic [15:0] i_rdData,
  input  logic        i_enable,
  input  logic        i_master_ready,
  output logic [7:0]  o_TXByte,
  output logic        o_TXdv,
  output logic        o_cs_n,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    WAITLOW,
    WAITHIGH,
    FINISH,
    GAP
  } state_t;

  state_t      state_q,    state_d;
  logic [15:0] dirty_q,    dirty_d;
  logic [3:0]  rr_ptr_q,   rr_ptr_d;
  logic [3:0]  channel_q,  channel_d;
  logic [3:0]  raddr_q,    raddr_d;
  logic [23:0] frame_q,    frame_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  gap_cnt_q,  gap_cnt_d;
  logic [7:0]  tx_byte_q,  tx_byte_d;
  logic        tx_dv_q,    tx_dv_d;
  logic        cs_n_q,     cs_n_d;
  logic        done_q,     done_d;

  logic        pick_valid;
  logic [3:0]  pick_ch;
  logic [3:0]  cand;

  // Round-robin arbiter. Scan the 16 channels starting at rr_ptr and
  // wrapping past 15 back to 0. The first dirty channel found wins. rr_ptr
  // always points just past the last channel sent, so a busy channel cannot
  // starve the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = 4'd0;
    cand       = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = rr_ptr_q + 4'(i);
      if (!pick_valid && dirty_q[cand]) begin
        pick_valid = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  // Next-state and datapath logic. All registers hold by default. The
  // strobes (o_TXdv, o_done) default low, so each lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    dirty_d    = dirty_q;
    rr_ptr_d   = rr_ptr_q;
    channel_d  = channel_q;
    raddr_d    = raddr_q;
    frame_d    = frame_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_enable && pick_valid) begin
          raddr_d   = pick_ch;
          channel_d = pick_ch;
          state_d   = READ;
        end
      end

      // The register file has one cycle of read latency.
      READ: begin
        state_d = LATCH;
      end

      // The frame is frozen here. Later writes only mark channels dirty
      // again; they never change a frame already in progress.
      LATCH: begin
        frame_d             = {CMD_CODE, channel_q, i_rdData};
        dirty_d[channel_q]  = 1'b0;
        rr_ptr_d            = channel_q + 4'd1;
        cs_n_d              = 1'b0;
        byte_idx_d          = 2'd0;
        state_d             = SEND;
      end

      SEND: begin
        if (i_master_ready) begin
          tx_dv_d = 1'b1;
          case (byte_idx_q)
            2'd0:    tx_byte_d = frame_q[23:16];
            2'd1:    tx_byte_d = frame_q[15:8];
            default: tx_byte_d = frame_q[7:0];
          endcase
          state_d = WAITLOW;
        end
      end

      // The master needs up to one cycle to drop ready after o_TXdv. We
      // wait to see it low, so the old ready is not taken as byte done.
      WAITLOW: begin
        if (!i_master_ready) begin
          state_d = WAITHIGH;
        end
      end

      WAITHIGH: begin
        if (i_master_ready) begin
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = SEND;
          end else begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        cs_n_d    = 1'b1;
        done_d    = 1'b1;
        gap_cnt_d = 4'(CS_GAP);
        state_d   = GAP;
      end

      // The counter is loaded with CS_GAP and counts down to zero. GAP
      // therefore lasts CS_GAP+1 cycles with chip select high.
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A write is applied after the LATCH clear. If the channel being sent
    // is rewritten in that same cycle, it stays dirty and is sent again.
    if (i_write) begin
      dirty_d[i_waddr] = 1'b1;
    end
  end

  // State register. Reset is asynchronous, so chip select rises and
  // o_TXdv drops at once, even mid-frame, and pending dirty bits are lost.
  always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
    if (!i_FPGA_rst) begin
      state_q    <= IDLE;
      dirty_q    <= 16'd0;
      rr_ptr_q   <= 4'd0;
      channel_q  <= 4'd0;
      raddr_q    <= 4'd0;
      frame_q    <= 24'd0;
      byte_idx_q <= 2'd0;
      gap_cnt_q  <= 4'd0;
      tx_byte_q  <= 8'd0;
      tx_dv_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dirty_q    <= dirty_d;
      rr_ptr_q   <= rr_ptr_d;
      channel_q  <= channel_d;
      raddr_q    <= raddr_d;
      frame_q    <= frame_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
    end
  end

  assign o_raddr  = raddr_q;
  assign o_TXByte = tx_byte_q;
  assign o_TXdv   = tx_dv_q;
  assign o_cs_n   = cs_n_q;
  assign o_done   = done_q;
  assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dac_update_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_update_sequencer
//
// Bench for dac_update_sequencer. It contains three models:
//   - a register file with one cycle of read latency, written via i_write;
//   - an SPI byte master that drops ready after each byte and raises it
//     again after a random delay;
//   - a frame monitor that assembles transmitted bytes into 24-bit frames.
// The expected frames come from a simple model. It keeps the set of dirty
// channels, the latest data per channel, and the next round-robin start.
// ---------------------------------------------------------------------------
module tb_dac_update_sequencer;

  localparam int         GAP_CYCLES = 4;
  localparam logic [3:0] CMD        = 4'b0011;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        write        = 1'b0;
  logic [3:0]  waddr        = 4'd0;
  logic [15:0] wdata        = 16'd0;
  logic [15:0] rd_data      = 16'd0;
  logic        enable       = 1'b0;
  logic        master_ready = 1'b1;
  logic [3:0]  raddr;
  logic [7:0]  tx_byte;
  logic        tx_dv;
  logic        cs_n;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [15:0] regs [16];
  logic [3:0]  prev_raddr;

  logic [7:0]  bytes_q [$];
  logic [23:0] got_frames [$];
  logic [23:0] exp_frames [$];
  int          byte_cnt  = 0;
  int          hi_cnt    = 0;
  int          last_gap  = 0;
  int          mcnt      = 0;
  bit          have_prev = 1'b0;

  logic [15:0] model_dirty;
  logic [15:0] model_data [16];
  logic [3:0]  model_ptr;

  dac_update_sequencer #(
    .CMD_CODE (CMD),
    .CS_GAP   (GAP_CYCLES)
  ) dut (
    .i_FPGA_clk     (clk),
    .i_FPGA_rst     (rst_n),
    .i_write        (write),
    .i_waddr        (waddr),
    .o_raddr        (raddr),
    .i_rdData       (rd_data),
    .i_enable       (enable),
    .i_master_ready (master_ready),
    .o_TXByte       (tx_byte),
    .o_TXdv         (tx_dv),
    .o_cs_n         (cs_n),
    .o_busy         (busy),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Register file. The read data follows the address that was present
  // through the previous cycle, and the read happens before the write.
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'd0;
    prev_raddr = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      rd_data = regs[prev_raddr];
      if (write) regs[waddr] = wdata;
      prev_raddr = raddr;
    end
  end

  // SPI master and frame monitor. It also measures how long chip select
  // stays high between one frame and the next.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        master_ready = 1'b1;
        mcnt         = 0;
        byte_cnt     = 0;
        bytes_q.delete();
        have_prev    = 1'b0;
        hi_cnt       = 0;
      end else begin
        if (tx_dv) begin
          check_output("txdv_cs_low", 32'(cs_n), 32'(0));
          bytes_q.push_back(tx_byte);
          byte_cnt++;
          master_ready = 1'b0;
          mcnt         = int'($urandom_range(3, 0));
        end else if (!master_ready) begin
          if (mcnt == 0) master_ready = 1'b1;
          else mcnt--;
        end
        if (done) begin
          check_output("done_byte_count", 32'(byte_cnt), 32'(3));
          check_output("done_cs_high", 32'(cs_n), 32'(1));
          if (bytes_q.size() >= 3) got_frames.push_back({bytes_q[0], bytes_q[1], bytes_q[2]});
          else got_frames.push_back(24'd0);
          bytes_q.delete();
          byte_cnt  = 0;
          have_prev = 1'b1;
          hi_cnt    = 1;
        end else if (have_prev) begin
          if (cs_n) begin
            hi_cnt++;
          end else begin
            check_output("gap_min", 32'(hi_cnt >= GAP_CYCLES + 1), 32'(1));
            last_gap  = hi_cnt;
            have_prev = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_write(input logic [3:0] ch, input logic [15:0] d);
    write = 1'b1;
    waddr = ch;
    wdata = d;
    model_dirty[ch] = 1'b1;
    model_data[ch]  = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  // Drains every dirty channel into the expected list. The scan starts at
  // the round-robin pointer, so the expected order is ascending from the
  // pointer, wrapping past channel 15 to channel 0.
  task automatic flush_model;
    logic [3:0] ch;
    logic [3:0] start;
    start = model_ptr;
    for (int k = 0; k < 16; k++) begin
      ch = start + 4'(k);
      if (model_dirty[ch]) begin
        exp_frames.push_back({CMD, ch, model_data[ch]});
        model_dirty[ch] = 1'b0;
        model_ptr       = ch + 4'd1;
      end
    end
  endtask

  task automatic apply_reset;
    rst_n       = 1'b0;
    model_dirty = 16'd0;
    model_ptr   = 4'd0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_quiet;
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 12 && n < 1500) begin
      @(negedge clk);
      n++;
      if (!busy && !tx_dv) quiet++;
      else quiet = 0;
    end
    if (quiet < 12) begin
      checks++;
      errors++;
      $error("[TB] FAIL quiet_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic wait_bytes(input int n);
    int c;
    c = 0;
    while (byte_cnt < n && c < 500) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (byte_cnt < n) begin
      checks++;
      errors++;
      $error("[TB] FAIL byte_timeout: saw %0d bytes, required %0d", byte_cnt, n);
    end
  endtask

  task automatic compare_frames(input string tag);
    check_output({tag, "_count"}, 32'(got_frames.size()), 32'(exp_frames.size()));
    for (int i = 0; i < exp_frames.size() && i < got_frames.size(); i++)
      check_output($sformatf("%s_frame%0d", tag, i), 32'(got_frames[i]), 32'(exp_frames[i]));
    got_frames.delete();
    exp_frames.delete();
  endtask

  initial begin
    int          n_wr;
    logic [3:0]  rch;
    logic [15:0] rdat;
    bit          found;

    for (int i = 0; i < 16; i++) model_data[i] = 16'd0;
    model_dirty = 16'd0;
    model_ptr   = 4'd0;

    // Reset state, observed while reset is held.
    tick(2);
    check_output("reset_cs_n", 32'(cs_n), 32'(1));
    check_output("reset_txdv", 32'(tx_dv), 32'(0));
    check_output("reset_busy", 32'(busy), 32'(0));
    check_output("reset_done", 32'(done), 32'(0));
    check_output("reset_raddr", 32'(raddr), 32'(0));
    check_output("reset_txbyte", 32'(tx_byte), 32'(0));
    rst_n = 1'b1;
    tick(1);

    // Single channel: ch3 = 0xABCD gives bytes 33 AB CD.
    enable = 1'b1;
    model_write(4'd3, 16'hABCD);
    wait_bytes(1);
    check_output("busy_mid_frame", 32'(busy), 32'(1));
    check_output("cs_low_mid_frame", 32'(cs_n), 32'(0));
    wait_quiet;
    flush_model;
    compare_frames("ch3");

    // Round-robin wrap from pointer 0: ch15 and ch0 are pending together,
    // so ch0 is sent first.
    enable = 1'b0;
    apply_reset;
    model_write(4'd15, 16'h0F0F);
    model_write(4'd0, 16'h1234);
    tick(3);
    check_output("no_start_disabled", 32'(busy), 32'(0));
    enable = 1'b1;
    wait_quiet;
    flush_model;
    compare_frames("rr_wrap");
    check_output("gap_back_to_back_min", 32'(last_gap >= GAP_CYCLES + 1), 32'(1));
    check_output("gap_back_to_back_max", 32'(last_gap <= GAP_CYCLES + 5), 32'(1));

    // Coalescing: two writes to ch5 give one frame with the newer data.
    enable = 1'b0;
    model_write(4'd5, 16'h1111);
    model_write(4'd5, 16'h2222);
    enable = 1'b1;
    wait_quiet;
    flush_model;
    compare_frames("coalesce");

    // A rewrite of ch7 during its LATCH cycle queues a second ch7 frame.
    enable = 1'b0;
    model_write(4'd7, 16'h7001);
    flush_model;
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (busy) found = 1'b1;
    end
    check_output("read_reached", 32'(found), 32'(1));
    @(negedge clk);
    check_output("latch_cs_high", 32'(cs_n), 32'(1));
    check_output("latch_raddr", 32'(raddr), 32'(7));
    model_write(4'd7, 16'h7002);
    check_output("send_cs_low", 32'(cs_n), 32'(0));
    wait_quiet;
    flush_model;
    compare_frames("latch_race");

    // Dropping enable during byte 1 lets the frame finish but blocks the next.
    enable = 1'b1;
    model_write(4'd9, 16'h9999);
    model_write(4'd10, 16'hA0A0);
    wait_bytes(2);
    enable = 1'b0;
    wait_quiet;
    check_output("enable_drop_one_frame", 32'(got_frames.size()), 32'(1));
    tick(20);
    check_output("enable_drop_held_off", 32'(got_frames.size()), 32'(1));
    check_output("enable_drop_idle", 32'(busy), 32'(0));
    enable = 1'b1;
    wait_quiet;
    flush_model;
    compare_frames("enable_drop");

    // Reset after byte 1: chip select rises at once and pending work is discarded.
    model_write(4'd2, 16'h2468);
    model_write(4'd4, 16'h1357);
    wait_bytes(2);
    rst_n = 1'b0;
    #1;
    check_output("midreset_cs_n", 32'(cs_n), 32'(1));
    check_output("midreset_txdv", 32'(tx_dv), 32'(0));
    check_output("midreset_busy", 32'(busy), 32'(0));
    check_output("midreset_raddr", 32'(raddr), 32'(0));
    check_output("midreset_txbyte", 32'(tx_byte), 32'(0));
    model_dirty = 16'd0;
    model_ptr   = 4'd0;
    tick(2);
    rst_n = 1'b1;
    wait_quiet;
    flush_model;
    compare_frames("after_reset");

    // Random batches: writes queued with enable low, then drained.
    for (int r = 0; r < 6; r++) begin
      enable = 1'b0;
      n_wr   = int'($urandom_range(6, 1));
      for (int w = 0; w < n_wr; w++) begin
        rch  = 4'($urandom_range(15, 0));
        rdat = 16'($urandom);
        model_write(rch, rdat);
      end
      enable = 1'b1;
      wait_quiet;
      flush_model;
      compare_frames($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
